// File: rtl/add_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial signed adder.
package add_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Overflow when both operands share a sign that the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return ~(a_msb ^ b_msb) & (a_msb ^ s_msb);
  endfunction

endpackage

// File: rtl/signed_add_slice.sv
// One SLICE_W-bit adder slice with carry in/out; time-shared by the controller.
module signed_add_slice
  import add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_signed_add_ctrl.sv
// Adds two WIDTH-bit signed operands one nibble per cycle, LSB first, and flags
// signed overflow; valid/ready on both sides, no overlap between operations.
module serial_signed_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int unsigned N = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
  logic               c_sl;

  assign a_sl = a_q[SLICE_W*idx_q +: SLICE_W];
  assign b_sl = b_q[SLICE_W*idx_q +: SLICE_W];

  signed_add_slice u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .s    (s_sl),
    .cout (c_sl)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (up_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = s_sl;
        carry_d = c_sl;
        if (idx_q == LAST_IDX) begin
          // Top carry-out is dropped; overflow comes from the sign bits alone.
          ovf_d   = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], s_sl[SLICE_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (down_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign up_ready   = (state_q == IDLE);
  assign down_valid = (state_q == DONE);
  assign sum        = sum_q;
  assign overflow   = ovf_q;

endmodule
